// File: rtl/hazard_flush_controller.sv
// rtl/hazard_flush_controller.sv - pipeline sequencer: load-use stall, mispredict flush, dmem freeze (optional HAZARD_PERF_CNT_EN counters)
module hazard_flush_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch,
    input  logic        ex_prediction,
    input  logic        ex_taken,
    input  logic        dmem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_hold,
    output logic        redirect,
    output logic        redirect_taken,
    output logic        mem_timeout,
    output logic [1:0]  ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] freeze_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_REDIRECT = 2'b01,
        S_MEM_WAIT = 2'b10
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] MT_V = WAIT_W'(MEM_TIMEOUT);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t            state, state_n;
    state_t            saved_state, saved_state_n;
    state_t            eval_state;
    logic [2:0]        flush_cnt, flush_cnt_n;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mispredict, load_use;
    logic              accept_mispredict, stall_now;

    assign mispredict = ex_branch & (ex_prediction != ex_taken);
    assign load_use   = ex_mem_read & (ex_rd != 5'd0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    // On the cycle busy drops, MEM_WAIT behaves exactly like the state it interrupted
    assign eval_state = (state == S_MEM_WAIT) ? saved_state : state;
    assign ctrl_state = state;

    // Next-state and pipeline control outputs, priority: freeze > redirect > mispredict > load-use
    always_comb begin
        pc_write          = 1'b1;
        ifid_write        = 1'b1;
        ifid_flush        = 1'b0;
        idex_flush        = 1'b0;
        pipe_hold         = 1'b0;
        redirect          = 1'b0;
        redirect_taken    = 1'b0;
        state_n           = state;
        saved_state_n     = saved_state;
        flush_cnt_n       = flush_cnt;
        accept_mispredict = 1'b0;
        stall_now         = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (dmem_busy) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_n    = S_MEM_WAIT;
            if (state != S_MEM_WAIT)
                saved_state_n = state;
        end else begin
            case (eval_state)
                S_REDIRECT: begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    flush_cnt_n = flush_cnt - 3'd1;
                    state_n     = (flush_cnt <= 3'd1) ? S_RUN : S_REDIRECT;
                end
                default: begin
                    state_n = S_RUN;
                    if (mispredict) begin
                        redirect          = 1'b1;
                        redirect_taken    = ex_taken;
                        ifid_flush        = 1'b1;
                        idex_flush        = 1'b1;
                        accept_mispredict = 1'b1;
                        flush_cnt_n       = FLUSH_INIT;
                        state_n           = (FLUSH_CYCLES > 1) ? S_REDIRECT : S_RUN;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        stall_now  = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, saved state and redirect counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            saved_state <= S_RUN;
            flush_cnt   <= 3'd0;
        end else begin
            state       <= state_n;
            saved_state <= saved_state_n;
            flush_cnt   <= flush_cnt_n;
        end
    end

    // Busy-cycle watchdog; the count saturates at the limit and the flag is sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (!dmem_busy) begin
            wait_cnt <= '0;
        end else begin
            if (wait_cnt != MT_V)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if ((MEM_TIMEOUT != 0) && (wait_cnt == MT_V - WAIT_W'(1)))
                mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt      <= '0;
            mispredict_cnt <= '0;
            freeze_cnt     <= '0;
        end else begin
            if (stall_now && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (accept_mispredict && (mispredict_cnt != '1))
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            if (dmem_busy && (freeze_cnt != '1))
                freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_flush_controller.sv
// tb/tb_hazard_flush_controller.sv - directed self-checking bench for hazard_flush_controller
module tb_hazard_flush_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic       ex_branch, ex_prediction, ex_taken, dmem_busy;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
    logic       redirect, redirect_taken, mem_timeout;
    logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, mispredict_cnt, freeze_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Output order: pc_write ifid_write ifid_flush idex_flush pipe_hold redirect redirect_taken
    localparam logic [6:0] O_RESET = 7'b0011000;
    localparam logic [6:0] O_DEF   = 7'b1100000;
    localparam logic [6:0] O_STALL = 7'b0001000;
    localparam logic [6:0] O_MP_T  = 7'b1111011;
    localparam logic [6:0] O_MP_N  = 7'b1111010;
    localparam logic [6:0] O_FLUSH = 7'b1111000;
    localparam logic [6:0] O_HOLD  = 7'b0000100;

    hazard_flush_controller #(
        .FLUSH_CYCLES(3),
        .MEM_TIMEOUT (3),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .ex_branch     (ex_branch),
        .ex_prediction (ex_prediction),
        .ex_taken      (ex_taken),
        .dmem_busy     (dmem_busy),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .pipe_hold     (pipe_hold),
        .redirect      (redirect),
        .redirect_taken(redirect_taken),
        .mem_timeout   (mem_timeout),
        .ctrl_state    (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .mispredict_cnt(mispredict_cnt),
        .freeze_cnt    (freeze_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, redirect, redirect_taken};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs, state and watchdog flag together, one settle delay after inputs change
    task automatic chk_all(input string tag, input logic [6:0] o, input logic [1:0] st, input logic to);
        #1;
        chk({tag, ".outs"}, 32'(outs()), 32'(o));
        chk({tag, ".state"}, 32'(ctrl_state), 32'(st));
        chk({tag, ".timeout"}, 32'(mem_timeout), 32'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
        ex_branch = 0; ex_prediction = 0; ex_taken = 0; dmem_busy = 0;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        #1;
        chk_all("reset", O_RESET, 2'b00, 1'b0);
        tick(); tick();
        reset = 1'b0;
        chk_all("defaults", O_DEF, 2'b00, 1'b0);

        // Load-use through rs2, then load leaves EX
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        chk_all("lu_rs2", O_STALL, 2'b00, 1'b0);
        tick(); ex_mem_read = 0;
        chk_all("lu_after", O_DEF, 2'b00, 1'b0);
        // rs1 match, and rs2 match that is not actually read
        clr(); ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1;
        chk_all("lu_rs1", O_STALL, 2'b00, 1'b0);
        clr(); ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 0;
        chk_all("lu_unused", O_DEF, 2'b00, 1'b0);
        // x0 never stalls
        clr(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; id_uses_rs2 = 1;
        chk_all("x0_guard", O_DEF, 2'b00, 1'b0);

        // Mispredict not-taken->taken: 3 flush cycles, 2 in REDIRECT
        tick(); clr(); ex_branch = 1; ex_prediction = 0; ex_taken = 1;
        chk_all("mp_c1", O_MP_T, 2'b00, 1'b0);
        tick(); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        chk_all("mp_c2_ignore", O_FLUSH, 2'b01, 1'b0);
        tick(); clr();
        chk_all("mp_c3", O_FLUSH, 2'b01, 1'b0);
        tick();
        chk_all("mp_done", O_DEF, 2'b00, 1'b0);
        // Correct prediction does nothing; taken->not-taken redirects to PC+4
        ex_branch = 1; ex_prediction = 1; ex_taken = 1;
        chk_all("pred_ok", O_DEF, 2'b00, 1'b0);
        ex_taken = 0;
        chk_all("mp_nt", O_MP_N, 2'b00, 1'b0);
        tick(); clr(); tick(); tick();
        chk_all("mp_nt_done", O_DEF, 2'b00, 1'b0);

        // Freeze with a pending mispredict; watchdog trips after the 3rd busy cycle
        ex_branch = 1; ex_prediction = 0; ex_taken = 1; dmem_busy = 1;
        chk_all("frz_1", O_HOLD, 2'b00, 1'b0);
        tick(); chk_all("frz_2", O_HOLD, 2'b10, 1'b0);
        tick(); chk_all("frz_3", O_HOLD, 2'b10, 1'b0);
        tick(); chk_all("frz_4", O_HOLD, 2'b10, 1'b1);
        tick(); dmem_busy = 0;
        chk_all("frz_exit_mp", O_MP_T, 2'b10, 1'b1);
        tick(); clr();
        chk_all("frz_redir1", O_FLUSH, 2'b01, 1'b1);
        // Freeze in the middle of REDIRECT pauses the flush counter
        tick(); dmem_busy = 1;
        chk_all("redir_frz1", O_HOLD, 2'b01, 1'b1);
        tick(); chk_all("redir_frz2", O_HOLD, 2'b10, 1'b1);
        tick(); dmem_busy = 0;
        chk_all("redir_frz_exit", O_FLUSH, 2'b10, 1'b1);
        tick(); chk_all("redir_frz_done", O_DEF, 2'b00, 1'b1);

        // Watchdog alone: reset clears the sticky flag, 6 busy cycles
        reset = 1; #1;
        chk_all("wd_reset", O_RESET, 2'b00, 1'b0);
        tick(); reset = 0; dmem_busy = 1;
        chk_all("wd_b1", O_HOLD, 2'b00, 1'b0);
        tick(); chk_all("wd_b2", O_HOLD, 2'b10, 1'b0);
        tick(); chk_all("wd_b3", O_HOLD, 2'b10, 1'b0);
        tick(); chk_all("wd_b4", O_HOLD, 2'b10, 1'b1);
        tick(); tick(); chk_all("wd_b6", O_HOLD, 2'b10, 1'b1);
        tick(); dmem_busy = 0;
        chk_all("wd_exit", O_DEF, 2'b10, 1'b1);
        tick(); chk_all("wd_sticky", O_DEF, 2'b00, 1'b1);

        // Reset asserted on the 2nd REDIRECT cycle aborts immediately
        ex_branch = 1; ex_prediction = 0; ex_taken = 1;
        chk_all("rst_mp", O_MP_T, 2'b00, 1'b1);
        tick(); clr(); tick();
        chk_all("rst_redir2", O_FLUSH, 2'b01, 1'b1);
        reset = 1; #1;
        chk_all("rst_abort", O_RESET, 2'b00, 1'b0);
        tick(); reset = 0;
        chk_all("rst_release", O_DEF, 2'b00, 1'b0);
        tick(); chk_all("rst_no_residual", O_DEF, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
